mmu_result_collector: RTL and testbench

- Sits on the output side of the 2x2 systolic MMU and consumes the column partial sums `acc0_out`/`acc1_out`.
- Deskews column 1, which arrives COL_SKEW cycles after column 0, and sign-extends both columns.
- Accumulates into a per-row accumulator bank across K-tiles.
- Pushes completed result rows into an output FIFO drained via valid/ready by the downstream activation/store stage.

---
 rtl/mmu_result_collector.sv | 170 +++++++++++++++++
 tb/tb_mmu_result_collector.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mmu_result_collector.sv
// Purpose : deskews and sign-extends the two MMU column partial sums, accumulates them per row
//           across K-tiles, and queues completed rows in a show-ahead output FIFO.
// Latency : COL_SKEW+1 cycles from col0_valid (with col0_last) to out_valid when the FIFO is empty.
// Backpres: the input stream cannot stall. A completed row that arrives while the FIFO is full
//           and not popping is dropped, and overflow is set. The bank is still updated.
//
// Ports   : clk/reset (async, active-high); col0_valid/col0_addr/col0_accum/col0_last/acc0_in carry the
//           column 0 tag and data; acc1_in carries column 1, COL_SKEW cycles later;
//           out_valid/out_ready/out_data0/out_data1/out_count expose the result FIFO;
//           overflow is sticky and is cleared by clr_overflow.
// Config  : define ACC_SAT_EN to make accumulating adds saturate instead of wrapping.
module mmu_result_collector #(
    parameter int ROWS       = 4,
    parameter int ACC_W      = 32,
    parameter int COL_SKEW   = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          col0_valid,
    input  logic [$clog2(ROWS)-1:0]       col0_addr,
    input  logic                          col0_accum,
    input  logic                          col0_last,
    input  logic [15:0]                   acc0_in,
    input  logic [15:0]                   acc1_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_W-1:0]              out_data0,
    output logic [ACC_W-1:0]              out_data1,
    output logic [$clog2(FIFO_DEPTH):0]   out_count,
    output logic                          overflow,
    input  logic                          clr_overflow
);

    localparam int AW = $clog2(ROWS);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic          vld;
        logic [AW-1:0] addr;
        logic          accum;
        logic          last;
        logic [15:0]   a0;
    } tag_t;

    function automatic logic [ACC_W-1:0] sext(input logic [15:0] v);
        return ACC_W'($signed(v));
    endfunction

    function automatic logic [ACC_W-1:0] add_acc(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
`ifdef ACC_SAT_EN
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        // The sign bit and the guard bit disagree only when the add overflowed.
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return s[ACC_W-1:0];
`else
        return a + b;
`endif
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // ---------------- Stage A: align column 0 tag with column 1 ----------------
    tag_t tag_in, tag_b;
    assign tag_in = '{vld: col0_valid, addr: col0_addr, accum: col0_accum,
                      last: col0_last, a0: acc0_in};

    generate
        if (COL_SKEW == 0) begin : g_direct
            assign tag_b = tag_in;
        end else begin : g_skew
            tag_t skew_q [COL_SKEW];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < COL_SKEW; i++) skew_q[i] <= '0;
                end else begin
                    skew_q[0] <= tag_in;
                    for (int i = 1; i < COL_SKEW; i++) skew_q[i] <= skew_q[i-1];
                end
            end
            assign tag_b = skew_q[COL_SKEW-1];
        end
    endgenerate

    // ---------------- Stage B: read-modify-write of the accumulator bank ----------------
    logic [ACC_W-1:0] bank0_q [ROWS];
    logic [ACC_W-1:0] bank1_q [ROWS];
    logic [ACC_W-1:0] ext0, ext1, sum0, sum1;

    assign ext0 = sext(tag_b.a0);
    assign ext1 = sext(acc1_in);
    // Overwrite results never need saturation because a 16-bit value always fits.
    assign sum0 = tag_b.accum ? add_acc(bank0_q[tag_b.addr], ext0) : ext0;
    assign sum1 = tag_b.accum ? add_acc(bank1_q[tag_b.addr], ext1) : ext1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROWS; i++) begin
                bank0_q[i] <= '0;
                bank1_q[i] <= '0;
            end
        end else if (tag_b.vld) begin
            bank0_q[tag_b.addr] <= sum0;
            bank1_q[tag_b.addr] <= sum1;
        end
    end

    // ---------------- Output FIFO ----------------
    logic [ACC_W-1:0] mem0_q [FIFO_DEPTH];
    logic [ACC_W-1:0] mem1_q [FIFO_DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             push_req, push, pop, full, drop;

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign pop      = (count_q != '0) && out_ready;
    assign push_req = tag_b.vld && tag_b.last;
    // When the FIFO is full, a same-cycle pop frees the slot that the push then reuses.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
        // A new overflow takes priority over a same-cycle clear.
        if (drop)              ovf_d = 1'b1;
        else if (clr_overflow) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; stale contents are never visible because the output is gated by out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem0_q[wr_ptr_q] <= sum0;
            mem1_q[wr_ptr_q] <= sum1;
        end
    end

    assign out_valid = (count_q != '0);
    assign out_data0 = out_valid ? mem0_q[rd_ptr_q] : '0;
    assign out_data1 = out_valid ? mem1_q[rd_ptr_q] : '0;
    assign out_count = count_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_mmu_result_collector.sv
// Directed bench for mmu_result_collector. The main instance uses the default parameters.
// A second instance with ACC_W=16 and COL_SKEW=0 covers the wrap/saturate corner.
module tb_mmu_result_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        col0_valid, col0_accum, col0_last, out_ready, clr_overflow;
    logic [1:0]  col0_addr;
    logic [15:0] acc0_in, acc1_in;
    logic        out_valid, overflow;
    logic [31:0] out_data0, out_data1;
    logic [2:0]  out_count;

    logic        b_valid, b_accum, b_last, b_ready, b_clr;
    logic [1:0]  b_addr;
    logic [15:0] b_a0, b_a1;
    logic        b_out_valid, b_overflow;
    logic [15:0] b_d0, b_d1;
    logic [2:0]  b_count;

    logic [15:0] pend_a1;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    mmu_result_collector #(.ROWS(4), .ACC_W(32), .COL_SKEW(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .col0_valid(col0_valid), .col0_addr(col0_addr), .col0_accum(col0_accum),
        .col0_last(col0_last), .acc0_in(acc0_in), .acc1_in(acc1_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1), .out_count(out_count),
        .overflow(overflow), .clr_overflow(clr_overflow)
    );

    mmu_result_collector #(.ROWS(4), .ACC_W(16), .COL_SKEW(0), .FIFO_DEPTH(4)) dut16 (
        .clk(clk), .reset(reset),
        .col0_valid(b_valid), .col0_addr(b_addr), .col0_accum(b_accum),
        .col0_last(b_last), .acc0_in(b_a0), .acc1_in(b_a1),
        .out_valid(b_out_valid), .out_ready(b_ready),
        .out_data0(b_d0), .out_data1(b_d1), .out_count(b_count),
        .overflow(b_overflow), .clr_overflow(b_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one column 0 tag. acc1_in carries the column 1 value from the previous call,
    // which models the one-cycle skew.
    task automatic feed(input logic v, input logic [1:0] ad, input logic ac, input logic la,
                        input logic [15:0] x0, input logic [15:0] x1);
        col0_valid = v;
        col0_addr  = ad;
        col0_accum = ac;
        col0_last  = la;
        acc0_in    = x0;
        acc1_in    = pend_a1;
        pend_a1    = x1;
        tick();
    endtask

    task automatic idle();
        feed(1'b0, 2'd0, 1'b0, 1'b0, 16'd0, 16'd0);
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        idle();
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        col0_valid = 0; col0_addr = 0; col0_accum = 0; col0_last = 0;
        acc0_in = 0; acc1_in = 0; out_ready = 0; clr_overflow = 0; pend_a1 = 0;
        b_valid = 0; b_addr = 0; b_accum = 0; b_last = 0; b_a0 = 0; b_a1 = 0;
        b_ready = 0; b_clr = 0;
        #3;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_data0", out_data0, 32'd0);
        @(posedge clk); #1; reset = 1'b0;
        tick();

        // A single overwrite with last set. The result appears two cycles after the tag.
        feed(1'b1, 2'd2, 1'b0, 1'b1, 16'd5, 16'hFFFD);
        check("lat_not_yet", 32'(out_valid), 32'd0);
        idle();
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_d0", out_data0, 32'd5);
        check("single_d1", out_data1, 32'hFFFFFFFD);
        pop_one();
        check("single_popped", 32'(out_valid), 32'd0);
        // Read back bank[2] by accumulating +1/+1 into it.
        feed(1'b1, 2'd2, 1'b1, 1'b1, 16'd1, 16'd1);
        idle();
        check("bank2_d0", out_data0, 32'd6);
        check("bank2_d1", out_data1, 32'hFFFFFFFE);
        pop_one();

        // Accumulate over three tiles with one push: 100-40+7=67 and 1+2+3=6.
        feed(1'b1, 2'd1, 1'b0, 1'b0, 16'd100, 16'd1);
        feed(1'b1, 2'd1, 1'b1, 1'b0, 16'hFFD8, 16'd2);
        feed(1'b1, 2'd1, 1'b1, 1'b1, 16'd7, 16'd3);
        idle();
        check("acc3_count", 32'(out_count), 32'd1);
        check("acc3_d0", out_data0, 32'd67);
        check("acc3_d1", out_data1, 32'd6);
        idle();
        check("acc3_one_push", 32'(out_count), 32'd1);
        pop_one();

        // Five completed rows against a stalled consumer: four are kept and one is dropped.
        for (int i = 0; i < 5; i++)
            feed(1'b1, 2'(i % 4), 1'b0, 1'b1, 16'(11 + i), 16'(-(11 + i)));
        idle();
        check("ovf_count", 32'(out_count), 32'd4);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_head", out_data0, 32'd11);
        idle();
        check("ovf_head_stable", out_data0, 32'd11);
        clr_overflow = 1'b1;
        idle();
        clr_overflow = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", 32'(out_valid), 32'd1);
            check("drain_d0", out_data0, 32'(11 + i));
            check("drain_d1", out_data1, 32'(-(11 + i)));
            pop_one();
        end
        check("drain_empty", 32'(out_count), 32'd0);

        // A full FIFO with a simultaneous pop and push keeps occupancy at four.
        for (int i = 0; i < 4; i++)
            feed(1'b1, 2'(i), 1'b0, 1'b1, 16'(21 + i), 16'd0);
        idle();
        check("full_count", 32'(out_count), 32'd4);
        feed(1'b1, 2'd0, 1'b0, 1'b1, 16'd25, 16'd0);
        out_ready = 1'b1;
        idle();
        out_ready = 1'b0;
        check("pp_count", 32'(out_count), 32'd4);
        check("pp_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("pp_drain_d0", out_data0, 32'(22 + i));
            pop_one();
        end
        check("pp_empty", 32'(out_valid), 32'd0);

        // Asynchronous reset between a column 0 tag and its column 1 value.
        feed(1'b1, 2'd2, 1'b0, 1'b1, 16'd9, 16'd9);
        idle();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        feed(1'b1, 2'd3, 1'b0, 1'b1, 16'd50, 16'd60);
        #2;
        reset = 1'b1;
        col0_valid = 1'b0;
        acc1_in = 16'd60;
        #1;
        check("rst_async_valid", 32'(out_valid), 32'd0);
        check("rst_async_count", 32'(out_count), 32'd0);
        @(posedge clk); #1; reset = 1'b0;
        idle();
        idle();
        check("no_push_after_rst", 32'(out_valid), 32'd0);
        feed(1'b1, 2'd2, 1'b1, 1'b1, 16'd7, 16'd8);
        idle();
        check("bank_zero_d0", out_data0, 32'd7);
        check("bank_zero_d1", out_data1, 32'd8);
        pop_one();

        // Narrow accumulator with zero skew: 32000 + 1000.
        b_valid = 1'b1; b_addr = 2'd0; b_accum = 1'b0; b_last = 1'b0;
        b_a0 = 16'd32000; b_a1 = 16'd0;
        tick();
        check("n16_no_last", 32'(b_out_valid), 32'd0);
        b_accum = 1'b1; b_last = 1'b1; b_a0 = 16'd1000;
        tick();
        b_valid = 1'b0; b_last = 1'b0;
        check("n16_valid", 32'(b_out_valid), 32'd1);
`ifdef ACC_SAT_EN
        check("n16_sat", 32'(b_d0), 32'h0000_7FFF);
`else
        check("n16_wrap", 32'(b_d0), 32'h0000_80E8);
`endif
        check("n16_d1", 32'(b_d1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
